// File: rtl/minitb_ahb_arbiter.sv
`default_nettype none
// ===========================================================================
// Module  : minitb_ahb_arbiter
// Purpose : Shares one AHB-lite master port between NUM_REQ single-beat
//           requesters; round-robin by default, fixed priority when
//           MINITB_AHB_ARB_FIXED_PRIO_EN is defined.
// Revision: 1.0 - initial release
// ===========================================================================
module minitb_ahb_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*addrWidth-1:0] req_addr,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*dataWidth-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           ack,
  output logic [dataWidth-1:0]         rsp_rdata,
  output logic [NUM_REQ-1:0]           grant,
  output logic [1:0]                   htrans,
  output logic [addrWidth-1:0]         haddr,
  output logic                         hwrite,
  output logic [dataWidth-1:0]         hwdata,
  input  logic                         hready,
  input  logic [dataWidth-1:0]         hrdata
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDXW-1:0]      last_q, last_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [dataWidth-1:0] rdata_q, rdata_d;
  logic [1:0]           htrans_q, htrans_d;
  logic [addrWidth-1:0] haddr_q, haddr_d;
  logic                 hwrite_q, hwrite_d;
  logic [dataWidth-1:0] hwdata_q, hwdata_d;
  logic [dataWidth-1:0] wdata_q, wdata_d;

  logic [IDXW-1:0]      win_idx;
  logic                 win_found;
  logic [addrWidth-1:0] win_addr;
  logic                 win_write;
  logic [dataWidth-1:0] win_wdata;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [NUM_REQ-1:0]   owner_onehot;

`ifdef MINITB_AHB_ARB_FIXED_PRIO_EN
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_idx   = IDXW'(k);
        win_found = 1'b1;
      end
    end
  end
`else
  logic [IDXW-1:0] cand;

  // Walk the search order backwards so the nearest requester after last_q wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDXW'((int'(last_q) + k) % NUM_REQ);
      if (req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    win_addr     = '0;
    win_write    = 1'b0;
    win_wdata    = '0;
    win_onehot   = '0;
    owner_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDXW'(k)) begin
        win_addr      = req_addr[k*addrWidth +: addrWidth];
        win_write     = req_write[k];
        win_wdata     = req_wdata[k*dataWidth +: dataWidth];
        win_onehot[k] = 1'b1;
      end
      if (last_q == IDXW'(k)) begin
        owner_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: begin
        // No arbitration while ack is out: the finished requester is still dropping req.
        if (win_found && (ack_q == '0)) begin
          state_d  = S_ADDR;
          last_d   = win_idx;
          grant_d  = win_onehot;
          haddr_d  = win_addr;
          hwrite_d = win_write;
          wdata_d  = win_wdata;
          htrans_d = HTRANS_NONSEQ;
        end
      end
      S_ADDR: begin
        if (hready) begin
          htrans_d = HTRANS_IDLE;
          if (hwrite_q) begin
            hwdata_d = wdata_q;
          end
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (hready) begin
          ack_d = owner_onehot;
          if (!hwrite_q) begin
            rdata_d = hrdata;
          end
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q  <= S_IDLE;
      last_q   <= IDXW'(NUM_REQ - 1);
      grant_q  <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      wdata_q  <= wdata_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_rdata = rdata_q;
  assign grant     = grant_q;
  assign htrans    = htrans_q;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_minitb_ahb_arbiter.sv
`default_nettype none
// Testbench for minitb_ahb_arbiter: directed protocol scenarios followed by a
// randomized run checked against a transaction-level model of the arbitration rules.
module tb_minitb_ahb_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;
`ifdef MINITB_AHB_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          hclk, hresetn;
  logic [N-1:0]  req, req_write, ack, grant;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, hwdata, hrdata;
  logic [1:0]    htrans;
  logic [AW-1:0] haddr;
  logic          hwrite, hready;

  int errors = 0;
  int checks = 0;

  minitb_ahb_arbiter #(.NUM_REQ(N), .addrWidth(AW), .dataWidth(DW)) dut (
    .hclk(hclk), .hresetn(hresetn), .req(req), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .ack(ack), .rsp_rdata(rsp_rdata),
    .grant(grant), .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    req_addr[i*AW +: AW]  = a;
    req_write[i]          = w;
    req_wdata[i*DW +: DW] = d;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    hresetn = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    hready = 1'b1; hrdata = '0;
    tick(); tick();
    checks++; if (htrans !== 2'b00 || haddr !== '0 || hwrite !== 1'b0) begin errors++;
      $display("FAIL reset_addr: htrans=%h haddr=%h hwrite=%b required 0/0/0", htrans, haddr, hwrite); end
    checks++; if (hwdata !== '0) begin errors++; $display("FAIL reset_hwdata: got %h required 0", hwdata); end
    checks++; if (ack !== '0 || grant !== '0) begin errors++;
      $display("FAIL reset_ack_grant: ack=%b grant=%b required 0/0", ack, grant); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h required 0", rsp_rdata); end
    hresetn = 1'b1;
    tick();
    checks++; if (grant !== '0 || htrans !== 2'b00) begin errors++;
      $display("FAIL idle_no_req: grant=%b htrans=%h required 0/0", grant, htrans); end
  endtask

  task automatic test_single_write();
    set_req(0, 8'h10, 1'b1, 32'hDEADBEEF);
    req = 3'b001;
    tick();
    checks++; if (htrans !== 2'b10 || haddr !== 8'h10 || hwrite !== 1'b1 || grant !== 3'b001) begin errors++;
      $display("FAIL write_addr: htrans=%h haddr=%h hwrite=%b grant=%b required 2/10/1/001", htrans, haddr, hwrite, grant); end
    tick();
    checks++; if (htrans !== 2'b00 || hwdata !== 32'hDEADBEEF || ack !== '0) begin errors++;
      $display("FAIL write_data: htrans=%h hwdata=%h ack=%b required 0/deadbeef/0", htrans, hwdata, ack); end
    tick();
    checks++; if (ack !== 3'b001 || grant !== '0) begin errors++;
      $display("FAIL write_ack: ack=%b grant=%b required 001/000", ack, grant); end
    tick();
    checks++; if (ack !== '0 || grant !== '0) begin errors++;
      $display("FAIL write_ack_suppress: ack=%b grant=%b required 000/000", ack, grant); end
    req = '0;
    tick();
  endtask

  task automatic test_read_wait();
    set_req(1, 8'h20, 1'b0, 32'h0);
    req = 3'b010; hready = 1'b1;
    tick();
    checks++; if (grant !== 3'b010 || htrans !== 2'b10 || haddr !== 8'h20 || hwrite !== 1'b0) begin errors++;
      $display("FAIL read_addr: grant=%b htrans=%h haddr=%h hwrite=%b required 010/2/20/0", grant, htrans, haddr, hwrite); end
    hready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (htrans !== 2'b10 || haddr !== 8'h20 || grant !== 3'b010) begin errors++;
        $display("FAIL read_addr_wait%0d: htrans=%h haddr=%h grant=%b required 2/20/010", i, htrans, haddr, grant); end
    end
    hready = 1'b1;
    tick();
    checks++; if (htrans !== 2'b00 || ack !== '0 || grant !== 3'b010) begin errors++;
      $display("FAIL read_data_entry: htrans=%h ack=%b grant=%b required 0/000/010", htrans, ack, grant); end
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hrdata = $urandom;
      tick();
      checks++; if (ack !== '0 || rsp_rdata !== '0 || grant !== 3'b010) begin errors++;
        $display("FAIL read_data_wait%0d: ack=%b rsp=%h grant=%b required 000/0/010", i, ack, rsp_rdata, grant); end
    end
    hready = 1'b1; hrdata = 32'h12345678;
    tick();
    checks++; if (ack !== 3'b010 || rsp_rdata !== 32'h12345678 || grant !== '0) begin errors++;
      $display("FAIL read_ack: ack=%b rsp=%h grant=%b required 010/12345678/000", ack, rsp_rdata, grant); end
    hrdata = '0;
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_contention();
    int exp_w;
    set_req(0, 8'h30, 1'b1, 32'hA0A00000);
    set_req(1, 8'h34, 1'b1, 32'hB1B10001);
    req = 3'b011; hready = 1'b1;
    tick();
    for (int t = 0; t < 4; t++) begin
      exp_w = FIXED ? 0 : (t % 2);
      checks++; if (grant !== oh(exp_w) || htrans !== 2'b10 || haddr !== ((exp_w == 0) ? 8'h30 : 8'h34)) begin errors++;
        $display("FAIL contention_grant%0d: grant=%b htrans=%h haddr=%h required grant %b", t, grant, htrans, haddr, oh(exp_w)); end
      tick();
      checks++; if (hwdata !== ((exp_w == 0) ? 32'hA0A00000 : 32'hB1B10001)) begin errors++;
        $display("FAIL contention_hwdata%0d: got %h", t, hwdata); end
      tick();
      checks++; if (ack !== oh(exp_w) || grant !== '0) begin errors++;
        $display("FAIL contention_ack%0d: ack=%b grant=%b required %b/000", t, ack, grant, oh(exp_w)); end
      tick();
      checks++; if (grant !== '0 || htrans !== 2'b00) begin errors++;
        $display("FAIL contention_turnaround%0d: grant=%b htrans=%h required 000/0", t, grant, htrans); end
      if (t == 3) req = '0;
      tick();
    end
    checks++; if (grant !== '0) begin errors++; $display("FAIL contention_release: grant=%b required 000", grant); end
  endtask

  task automatic test_wrap();
    set_req(2, 8'h40, 1'b0, 32'h0);
    req = 3'b100; hready = 1'b1;
    tick();
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL wrap_setup: grant=%b required 100", grant); end
    tick(); tick();
    set_req(0, 8'h41, 1'b0, 32'h0); set_req(1, 8'h42, 1'b0, 32'h0);
    req = 3'b011;
    tick();
    checks++; if (grant !== '0) begin errors++; $display("FAIL wrap_suppress1: grant=%b required 000", grant); end
    tick();
    checks++; if (grant !== 3'b001 || haddr !== 8'h41) begin errors++;
      $display("FAIL wrap_last2: grant=%b haddr=%h required 001/41", grant, haddr); end
    req = 3'b001;
    tick(); tick();
    set_req(0, 8'h43, 1'b0, 32'h0); set_req(2, 8'h44, 1'b0, 32'h0);
    req = 3'b101;
    tick();
    checks++; if (grant !== '0) begin errors++; $display("FAIL wrap_suppress2: grant=%b required 000", grant); end
    tick();
    checks++; if (grant !== (FIXED ? 3'b001 : 3'b100) || haddr !== (FIXED ? 8'h43 : 8'h44)) begin errors++;
      $display("FAIL wrap_last0: grant=%b haddr=%h required %b", grant, haddr, FIXED ? 3'b001 : 3'b100); end
    tick(); tick();
    checks++; if (ack !== (FIXED ? 3'b001 : 3'b100)) begin errors++; $display("FAIL wrap_ack: ack=%b", ack); end
    req = '0;
    tick(); tick();
    checks++; if (grant !== '0) begin errors++; $display("FAIL wrap_release: grant=%b required 000", grant); end
  endtask

  task automatic test_reset_mid();
    set_req(0, 8'h50, 1'b0, 32'h0);
    req = 3'b001; hready = 1'b1;
    tick();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL rstmid_grant0: grant=%b required 001", grant); end
    tick();
    hready = 1'b0;
    set_req(1, 8'h54, 1'b1, 32'hC3C3C3C3);
    req = 3'b011;
    tick();
    checks++; if (grant !== 3'b001 || ack !== '0) begin errors++;
      $display("FAIL rstmid_hold: grant=%b ack=%b required 001/000", grant, ack); end
    hresetn = 1'b0; req = 3'b010;
    tick();
    checks++; if ({htrans, haddr, hwrite, hwdata, ack, grant, rsp_rdata} !== '0) begin errors++;
      $display("FAIL rstmid_zero: htrans=%h haddr=%h hwrite=%b hwdata=%h ack=%b grant=%b rsp=%h required all 0",
               htrans, haddr, hwrite, hwdata, ack, grant, rsp_rdata); end
    hresetn = 1'b1; hready = 1'b1;
    tick();
    checks++; if (grant !== 3'b010 || haddr !== 8'h54 || hwrite !== 1'b1 || ack !== '0) begin errors++;
      $display("FAIL rstmid_regrant: grant=%b haddr=%h hwrite=%b ack=%b required 010/54/1/000", grant, haddr, hwrite, ack); end
    tick();
    checks++; if (hwdata !== 32'hC3C3C3C3) begin errors++; $display("FAIL rstmid_hwdata: got %h required c3c3c3c3", hwdata); end
    tick();
    checks++; if (ack !== 3'b010) begin errors++; $display("FAIL rstmid_ack: ack=%b required 010", ack); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_withdraw();
    set_req(0, 8'h60, 1'b1, 32'hD4D4D4D4);
    req = 3'b001; hready = 1'b1;
    tick();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL withdraw_grant0: grant=%b required 001", grant); end
    tick();
    hready = 1'b0;
    set_req(1, 8'h64, 1'b0, 32'h0);
    req = 3'b011;
    tick();
    req = 3'b001;
    tick(); tick();
    hready = 1'b1;
    tick();
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL withdraw_ack0: ack=%b required 001", ack); end
    req = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (grant[1] !== 1'b0 || ack[1] !== 1'b0) begin errors++;
        $display("FAIL withdraw_no_serve%0d: grant=%b ack=%b required bit1 clear", i, grant, ack); end
    end
  endtask

  task automatic test_random();
    int last_m, owner, cyc, acks, total, w;
    bit in_addr, in_data, prev_ack;
    logic [AW-1:0] e_addr;
    logic e_write;
    logic [DW-1:0] e_wdata, e_rsp, hrdata_e;
    logic [N-1:0] req_e, wr_e, exp_ack, exp_grant, drop_next;
    logic [N*AW-1:0] addr_e;
    logic [N*DW-1:0] wd_e;
    logic hready_e;
    logic [1:0] exp_htrans;
    int remaining[N];
    hresetn = 1'b0; req = '0;
    tick();
    hresetn = 1'b1;
    last_m = N - 1; owner = 0; in_addr = 0; in_data = 0; prev_ack = 0;
    e_rsp = '0; e_addr = '0; e_write = 1'b0; e_wdata = '0; drop_next = '0;
    acks = 0; total = 0; cyc = 0;
    for (int i = 0; i < N; i++) begin remaining[i] = 12; total += 12; end
    hready = 1'b1; hrdata = $urandom;
    while ((acks < total || req != '0) && cyc < 3000) begin
      req_e = req; addr_e = req_addr; wr_e = req_write; wd_e = req_wdata;
      hready_e = hready; hrdata_e = hrdata;
      tick();
      cyc++;
      exp_ack = '0;
      if (in_data) begin
        if (hready_e) begin
          exp_ack = oh(owner); in_data = 0;
          if (!e_write) e_rsp = hrdata_e;
        end
      end else if (in_addr) begin
        if (hready_e) begin
          in_addr = 0; in_data = 1;
          if (e_write) begin
            checks++; if (hwdata !== e_wdata) begin errors++;
              $display("FAIL rand_hwdata cyc%0d: got %h required %h", cyc, hwdata, e_wdata); end
          end
        end
      end else if (!prev_ack && req_e != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          int j;
          j = FIXED ? k : (last_m + 1 + k) % N;
          if (w < 0 && req_e[j]) w = j;
        end
        owner = w; last_m = w; in_addr = 1;
        e_addr = addr_e[w*AW +: AW]; e_write = wr_e[w]; e_wdata = wd_e[w*DW +: DW];
        checks++; if (haddr !== e_addr || hwrite !== e_write) begin errors++;
          $display("FAIL rand_payload cyc%0d: haddr=%h hwrite=%b required %h/%b", cyc, haddr, hwrite, e_addr, e_write); end
      end
      exp_grant  = (in_addr || in_data) ? oh(owner) : '0;
      exp_htrans = in_addr ? 2'b10 : 2'b00;
      checks++; if (ack !== exp_ack) begin errors++;
        $display("FAIL rand_ack cyc%0d: got %b required %b", cyc, ack, exp_ack); end
      checks++; if (grant !== exp_grant) begin errors++;
        $display("FAIL rand_grant cyc%0d: got %b required %b", cyc, grant, exp_grant); end
      checks++; if (htrans !== exp_htrans) begin errors++;
        $display("FAIL rand_htrans cyc%0d: got %h required %h", cyc, htrans, exp_htrans); end
      checks++; if (rsp_rdata !== e_rsp) begin errors++;
        $display("FAIL rand_rdata cyc%0d: got %h required %h", cyc, rsp_rdata, e_rsp); end
      prev_ack = (exp_ack != '0);
      if (exp_ack != '0) acks++;
      for (int i = 0; i < N; i++) begin
        if (drop_next[i]) begin
          req[i] = 1'b0; drop_next[i] = 1'b0;
        end else if (exp_ack[i]) begin
          drop_next[i] = 1'b1; remaining[i]--;
        end else if ((in_addr || in_data) && owner == i) begin
          req[i] = 1'b1;
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
          else if ($urandom_range(0, 7) == 0) set_req(i, AW'($urandom), 1'($urandom_range(0, 1)), $urandom);
        end else if (remaining[i] > 0 && $urandom_range(0, 2) == 0) begin
          set_req(i, AW'($urandom), 1'($urandom_range(0, 1)), $urandom);
          req[i] = 1'b1;
        end
      end
      hready = ($urandom_range(0, 3) != 0);
      hrdata = $urandom;
    end
    checks++; if (acks != total || cyc >= 3000) begin errors++;
      $display("FAIL rand_completion: acks=%0d required %0d within 3000 cycles (used %0d)", acks, total, cyc); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_wrap();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
